// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x4 matrix keypad scanner. Drives one row at a time,
//                synchronises the asynchronous column returns through two
//                flops, reduces each full sweep to a single (lowest) key
//                code, and debounces that code across DEBOUNCE_CNT
//                consecutive sweeps before reporting a press or release.
//  Ports       :
//    clk        - system (pixel) clock
//    rst        - synchronous reset, active-high
//    key_col    - column returns, active-high, asynchronous
//    key_row    - one-hot row drive, active-high
//    key        - {valid, code} of the held key, 5'h00 when none
//    key_pulse  - equals key for one cycle on each accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [4:0] key,
    output logic [4:0] key_pulse
);

    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_cnt_w = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_target = c_cnt_w'(DEBOUNCE_CNT);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Column synchroniser
    // ------------------------------------------------------------------
    logic [3:0] col_s1_q;
    logic [3:0] col_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1_q <= 4'b0000;
            col_s2_q <= 4'b0000;
        end else begin
            col_s1_q <= key_col;
            col_s2_q <= col_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Row scan and per-sweep reduction
    // ------------------------------------------------------------------
    logic [c_div_w-1:0] div_q;
    logic [1:0]         row_q;
    logic               acc_valid_q;
    logic [3:0]         acc_code_q;
    logic               sweep_evt_q;
    logic               sweep_valid_q;
    logic [3:0]         sweep_code_q;

    logic               w_hit;
    logic [1:0]         w_col_lo;
    logic [3:0]         w_row_code;

    // Lowest active column of the current row; rows are visited in
    // ascending order, so the first hit of a sweep is the lowest code.
    always_comb begin
        w_hit    = |col_s2_q;
        w_col_lo = 2'd0;
        if (col_s2_q[0]) begin
            w_col_lo = 2'd0;
        end else if (col_s2_q[1]) begin
            w_col_lo = 2'd1;
        end else if (col_s2_q[2]) begin
            w_col_lo = 2'd2;
        end else if (col_s2_q[3]) begin
            w_col_lo = 2'd3;
        end
        w_row_code = {row_q, w_col_lo};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            row_q         <= 2'd0;
            acc_valid_q   <= 1'b0;
            acc_code_q    <= 4'd0;
            sweep_evt_q   <= 1'b0;
            sweep_valid_q <= 1'b0;
            sweep_code_q  <= 4'd0;
        end else begin
            sweep_evt_q <= 1'b0;
            if (div_q == c_div_last) begin
                div_q <= '0;
                row_q <= row_q + 2'd1;
                if (row_q == 2'd3) begin
                    // Close the sweep and hand the result to the FSM.
                    sweep_evt_q   <= 1'b1;
                    sweep_valid_q <= acc_valid_q | w_hit;
                    sweep_code_q  <= acc_valid_q ? acc_code_q :
                                     (w_hit ? w_row_code : 4'd0);
                    acc_valid_q   <= 1'b0;
                    acc_code_q    <= 4'd0;
                end else if (!acc_valid_q && w_hit) begin
                    acc_valid_q <= 1'b1;
                    acc_code_q  <= w_row_code;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [3:0]         cand_q,   cand_d;
    logic [c_cnt_w-1:0] cnt_q,    cnt_d;
    logic [4:0]         key_q,    key_d;
    logic [4:0]         pulse_q,  pulse_d;

    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_same;

    always_comb begin
        w_cnt_inc = (cnt_q == c_cnt_target) ? cnt_q : cnt_q + 1'b1;
        w_same    = sweep_valid_q && (sweep_code_q == cand_q);
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        pulse_d = 5'h00;

        if (sweep_evt_q) begin
            case (state_q)
                S_IDLE: begin
                    if (sweep_valid_q) begin
                        cand_d = sweep_code_q;
                        cnt_d  = c_cnt_one;
                        if (DEBOUNCE_CNT == 1) begin
                            state_d = S_HELD;
                            key_d   = {1'b1, sweep_code_q};
                            pulse_d = {1'b1, sweep_code_q};
                        end else begin
                            state_d = S_PRESS_WAIT;
                        end
                    end
                end

                S_PRESS_WAIT: begin
                    if (!sweep_valid_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (w_same) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_cnt_target) begin
                            state_d = S_HELD;
                            key_d   = {1'b1, cand_q};
                            pulse_d = {1'b1, cand_q};
                        end
                    end else begin
                        cand_d = sweep_code_q;
                        cnt_d  = c_cnt_one;
                    end
                end

                S_HELD: begin
                    if (!w_same) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state_d = S_IDLE;
                            key_d   = 5'h00;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_RELEASE_WAIT;
                            cnt_d   = c_cnt_one;
                        end
                    end
                end

                S_RELEASE_WAIT: begin
                    if (w_same) begin
                        // Bounce back to the held key: no new pulse.
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_cnt_target) begin
                            state_d = S_IDLE;
                            key_d   = 5'h00;
                            cnt_d   = '0;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    key_d   = 5'h00;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
            key_q   <= 5'h00;
            pulse_q <= 5'h00;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            pulse_q <= pulse_d;
        end
    end

    assign key_row   = 4'b0001 << row_q;
    assign key       = key_q;
    assign key_pulse = pulse_q;

endmodule
`default_nettype wire
